// File: rtl/aes_dec_scheduler.sv
// Round-robin scheduler sharing one combinational AES decrypt core between two channels.
// Optional per-channel completion counters: define AES_DEC_SCHED_STATS_EN.
module aes_dec_scheduler #(
    parameter int WAIT_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_ct,
    input  logic [127:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_ct,
    input  logic [127:0] req1_key,
    output logic [127:0] core_ct,
    output logic [127:0] core_key,
    input  logic [127:0] core_pt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_pt,
    output logic         out_id
`ifdef AES_DEC_SCHED_STATS_EN
   ,output logic [31:0]  blk_cnt0,
    output logic [31:0]  blk_cnt1
`endif
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 255) begin : g_bad_cfg
        $error("aes_dec_scheduler: WAIT_CYCLES must be in 1..255");
    end

    localparam logic [7:0] CNT_INIT = 8'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [7:0]   r_cnt;
    logic         r_last;
    logic         r_id;
    logic         r_out_valid;
    logic         r_out_id;
    logic [127:0] r_core_ct;
    logic [127:0] r_core_key;
    logic [127:0] r_out_pt;

    logic w_idle;
    logic w_any;
    logic w_grant;
    logic w_accept;
    logic w_capture;
    logic w_fire;

    // On a tie the channel that did not win last time gets the core.
    assign w_idle    = (r_state == S_IDLE);
    assign w_any     = req0_valid | req1_valid;
    assign w_grant   = (req0_valid && req1_valid) ? ~r_last : req1_valid;
    assign req0_ready = w_idle && req0_valid && !w_grant;
    assign req1_ready = w_idle && req1_valid && w_grant;
    assign w_accept  = w_idle && w_any;
    assign w_capture = (r_state == S_WAIT) && (r_cnt == 8'd0);
    assign w_fire    = r_out_valid && out_ready;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 8'd0) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_last      <= 1'b1;
            r_id        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_id    <= 1'b0;
            r_core_ct   <= '0;
            r_core_key  <= '0;
            r_out_pt    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_core_ct  <= w_grant ? req1_ct  : req0_ct;
                r_core_key <= w_grant ? req1_key : req0_key;
                r_last     <= w_grant;
                r_id       <= w_grant;
                r_cnt      <= CNT_INIT;
            end
            if (r_state == S_WAIT && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_capture) begin
                r_out_pt    <= core_pt;
                r_out_id    <= r_id;
                r_out_valid <= 1'b1;
            end
            if (w_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign core_ct   = r_core_ct;
    assign core_key  = r_core_key;
    assign out_valid = r_out_valid;
    assign out_pt    = r_out_pt;
    assign out_id    = r_out_id;

`ifdef AES_DEC_SCHED_STATS_EN
    logic [31:0] r_blk_cnt0;
    logic [31:0] r_blk_cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_cnt0 <= '0;
            r_blk_cnt1 <= '0;
        end else if (w_fire) begin
            if (r_out_id) r_blk_cnt1 <= r_blk_cnt1 + 32'd1;
            else          r_blk_cnt0 <= r_blk_cnt0 + 32'd1;
        end
    end

    assign blk_cnt0 = r_blk_cnt0;
    assign blk_cnt1 = r_blk_cnt1;
`endif

endmodule

// File: tb/tb_aes_dec_scheduler.sv
// Bench for aes_dec_scheduler: stand-in core, vector table and scoreboard.
module tb_aes_dec_scheduler;

    localparam int W = 4;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready;
    logic [127:0] req0_ct, req0_key;
    logic         req1_valid, req1_ready;
    logic [127:0] req1_ct, req1_key;
    logic [127:0] core_ct, core_key, core_pt;
    logic         out_valid, out_ready, out_id;
    logic [127:0] out_pt;
`ifdef AES_DEC_SCHED_STATS_EN
    logic [31:0]  blk_cnt0, blk_cnt1;
`endif

    // Stand-in core: exact FIPS-197 answer for the known vector, a keyed mix otherwise.
    function automatic logic [127:0] model(input logic [127:0] ct, input logic [127:0] key);
        if (ct == FIPS_CT && key == FIPS_KEY) return FIPS_PT;
        return ct ^ {key[63:0], key[127:64]} ^ 128'h5a5a_1234_a5a5_4321_0f0f_dead_beef_c0de;
    endfunction

    assign core_pt = model(core_ct, core_key);

    aes_dec_scheduler #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_ct(req0_ct), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_ct(req1_ct), .req1_key(req1_key),
        .core_ct(core_ct), .core_key(core_key), .core_pt(core_pt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pt(out_pt), .out_id(out_id)
`ifdef AES_DEC_SCHED_STATS_EN
       ,.blk_cnt0(blk_cnt0), .blk_cnt1(blk_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] pt;
        logic         id;
    } exp_t;

    typedef struct {
        logic         ch;
        logic [127:0] ct;
        logic [127:0] key;
        logic [127:0] pt;
        logic         id;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got result %h with empty scoreboard", out_pt);
            end else begin
                e = sb.pop_front();
                chk("sb_pt", out_pt, e.pt);
                chk("sb_id", 128'(out_id), 128'(e.id));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic ch, input logic [127:0] ct, input logic [127:0] key,
                        output int acc);
        bit ok;
        exp_t e;
        ok  = 1'b0;
        acc = 0;
        if (ch) begin req1_valid = 1'b1; req1_ct = ct; req1_key = key; end
        else    begin req0_valid = 1'b1; req0_ct = ct; req0_key = key; end
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if ((ch && req1_ready) || (!ch && req0_ready)) begin
                ok   = 1'b1;
                acc  = cyc;
                e.pt = model(ct, key);
                e.id = ch;
                sb.push_back(e);
            end
            tick();
        end
        if (ch) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: ch %0d accepted %0d required 1", ch, ok);
        end
    endtask

    task automatic wait_valid(output int c);
        bit ok;
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                c  = cyc;
            end else begin
                tick();
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_valid_timeout: out_valid %0d required 1", out_valid);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
        chk("drain_empty", 128'(sb.size()), 128'd0);
    endtask

    vec_t tbl[5];

    initial begin
        int acc;
        int c;
        int n_acc;
        logic exp_g;
        logic [127:0] a_ct;
        logic [127:0] a_key;
        logic [31:0] k0, k1;

        tbl[0] = '{1'b0, FIPS_CT, FIPS_KEY, FIPS_PT, 1'b0};
        tbl[1] = '{1'b1, FIPS_CT, FIPS_KEY, FIPS_PT, 1'b1};
        tbl[2] = '{1'b0, 128'h0, 128'h0, model(128'h0, 128'h0), 1'b0};
        tbl[3] = '{1'b1, '1, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210,
                   model('1, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210), 1'b1};
        tbl[4] = '{1'b0, 128'hdead_beef_0000_1111_2222_3333_4444_5555, '1,
                   model(128'hdead_beef_0000_1111_2222_3333_4444_5555, '1), 1'b0};

        req0_valid = 1'b0; req0_ct = '0; req0_key = '0;
        req1_valid = 1'b0; req1_ct = '0; req1_key = '0;
        out_ready  = 1'b1;
        rst        = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_pt", out_pt, 128'd0);
        chk("rst_out_id", 128'(out_id), 128'd0);
        chk("rst_core_ct", core_ct, 128'd0);
        chk("rst_core_key", core_key, 128'd0);
        rst = 1'b0;
        tick();

        // Single-request vectors, one per row, with latency and one-cycle DONE.
        foreach (tbl[i]) begin
            send(tbl[i].ch, tbl[i].ct, tbl[i].key, acc);
            chk("vec_core_ct", core_ct, tbl[i].ct);
            chk("vec_core_key", core_key, tbl[i].key);
            wait_valid(c);
            chk("vec_latency", 128'(c - acc), 128'(W + 1));
            chk("vec_pt", out_pt, tbl[i].pt);
            chk("vec_id", 128'(out_id), 128'(tbl[i].id));
            tick();
            chk("vec_done_1cyc", 128'(out_valid), 128'd0);
        end
        drain();

        // Both channels always valid: grants alternate starting with ch0.
        do_reset();
        exp_g = 1'b0;
        n_acc = 0;
        k0 = 0;
        k1 = 0;
        req0_key = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        req1_key = 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000;
        for (int i = 0; i < 200 && n_acc < 6; i++) begin
            exp_t e;
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_ct = {96'h0a0a0a0a_00000000_00000000, k0};
            req1_ct = {96'h0b0b0b0b_00000000_00000000, k1};
            #1;
            if (req0_ready && req1_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL alt_both_ready: got 2 grants required 1");
            end
            if (req0_ready || req1_ready) begin
                chk("alt_grant", 128'(req1_ready), 128'(exp_g));
                e.id = req1_ready;
                e.pt = req1_ready ? model(req1_ct, req1_key) : model(req0_ct, req0_key);
                sb.push_back(e);
                if (req1_ready) k1++;
                else            k0++;
                exp_g = ~exp_g;
                n_acc++;
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("alt_accepts", 128'(n_acc), 128'd6);
        chk("alt_ch0_count", 128'(k0), 128'd3);
        drain();

        // Back-pressure: result held for 10 cycles, no grants while blocked.
        out_ready = 1'b0;
        a_ct  = 128'hcafe_f00d_0000_0000_1234_5678_9abc_def0;
        a_key = 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
        send(1'b1, a_ct, a_key, acc);
        wait_valid(c);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_valid", 128'(out_valid), 128'd1);
            chk("bp_pt", out_pt, model(a_ct, a_key));
            chk("bp_id", 128'(out_id), 128'd1);
            chk("bp_rdy0", 128'(req0_ready), 128'd0);
            chk("bp_rdy1", 128'(req1_ready), 128'd0);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b1;
        tick();
        chk("bp_release", 128'(out_valid), 128'd0);
        chk("bp_sb_empty", 128'(sb.size()), 128'd0);
        req0_valid = 1'b1;
        #1;
        chk("bp_idle_ready", 128'(req0_ready), 128'd1);
        req0_valid = 1'b0;
        #1;

        // Requester changes its ciphertext mid-operation.
        tick();
        send(1'b0, a_ct, a_key, acc);
        req0_ct = '0;
        for (int i = 0; i < W; i++) begin
            chk("hold_core_ct", core_ct, a_ct);
            tick();
        end
        chk("hold_valid", 128'(out_valid), 128'd1);
        chk("hold_pt", out_pt, model(a_ct, a_key));
        tick();
        drain();

        // Reset in the middle of WAIT discards the block.
        send(1'b1, a_ct, a_key, acc);
        tick();
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        chk("abort_valid", 128'(out_valid), 128'd0);
        chk("abort_core_ct", core_ct, 128'd0);
        for (int i = 0; i < W + 3; i++) begin
            tick();
            chk("abort_no_valid", 128'(out_valid), 128'd0);
        end
        req1_valid = 1'b1;
        req1_ct = a_ct;
        req1_key = a_key;
        req0_valid = 1'b1;
        req0_ct = FIPS_CT;
        req0_key = FIPS_KEY;
        #1;
        chk("tie_rdy0", 128'(req0_ready), 128'd1);
        chk("tie_rdy1", 128'(req1_ready), 128'd0);
        send(1'b0, FIPS_CT, FIPS_KEY, acc);
        req1_valid = 1'b0;
        wait_valid(c);
        chk("abort_latency", 128'(c - acc), 128'(W + 1));
        chk("abort_pt", out_pt, FIPS_PT);
        tick();
        drain();

`ifdef AES_DEC_SCHED_STATS_EN
        do_reset();
        chk("stat_rst0", 128'(blk_cnt0), 128'd0);
        for (int i = 0; i < 5; i++) begin
            send((i % 2) == 1, 128'(i) ^ a_ct, a_key, acc);
            wait_valid(c);
            tick();
        end
        drain();
        chk("stat_cnt0", 128'(blk_cnt0), 128'd3);
        chk("stat_cnt1", 128'(blk_cnt1), 128'd2);
        force dut.r_blk_cnt0 = 32'hffff_ffff;
        tick();
        release dut.r_blk_cnt0;
        send(1'b0, a_ct, a_key, acc);
        wait_valid(c);
        tick();
        chk("stat_wrap", 128'(blk_cnt0), 128'd0);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
